dmem_arbiter: RTL and testbench

- Shares the single data memory port between two requesters: requester 0 (core load/store path) and requester 1 (debug/loader port that preloads data and dumps state).
- Requesters use a valid/ready handshake. The arbiter serialises one transaction at a time, drives the memory with registered command fields, and returns a one-cycle response to the owning requester.
- Sits between the core datapath and the data memory unit. It checks alignment per funct3 before any access.

---
 rtl/dmem_arb_pkg.sv | 38 +++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, RV32
// load/store size codes, requester indices and the access legality check.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  // Unsigned sizes only exist for loads; stores are limited to B/H/W.
  function automatic logic access_ok(input logic       we,
                                     input logic [2:0] funct3,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~addr_lo[0];
      F3_W:    ok = (addr_lo == 2'b00);
      F3_BU:   ok = ~we;
      F3_HU:   ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to
// whichever requester was not granted last. last_grant advances on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant_vld,
  output logic       grant
);

  logic last_grant;

  always_comb begin
    grant_vld = |valid;
    grant     = 1'b0;
    case (valid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = 1'b0;
    endcase
  end

  // Resetting to requester 1 hands the first tie to the core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises core and debug accesses onto the single data-memory port:
// accept -> issue -> (wait for read data) -> one-cycle response to the owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              req_valid_i,
  output logic [1:0]              req_ready_o,
  input  logic [1:0]              req_we_i,
  input  logic [2*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [2*DATA_WIDTH-1:0] req_wdata_i,
  input  logic [5:0]              req_funct3_i,
  output logic [1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [2:0]              mem_funct3_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic                    busy_o
);

  localparam int CNT_W = 2;

  arb_state_e state_q, state_d;

  logic                  grant_vld, grant, accept;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [2:0]            sel_funct3;

  logic                  we_q, err_q, owner_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
  logic [2:0]            funct3_q;
  logic [CNT_W-1:0]      cnt_q;

  rr_arbiter2 u_rr (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .valid     (req_valid_i),
    .accept    (accept),
    .grant_vld (grant_vld),
    .grant     (grant)
  );

  assign accept     = (state_q == IDLE) && grant_vld;
  assign sel_we     = req_we_i[grant];
  assign sel_addr   = grant ? req_addr_i[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr_i[ADDR_WIDTH-1:0];
  assign sel_wdata  = grant ? req_wdata_i[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata_i[DATA_WIDTH-1:0];
  assign sel_funct3 = grant ? req_funct3_i[5:3] : req_funct3_i[2:0];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld) state_d = ISSUE;
      ISSUE:   state_d = (err_q || we_q) ? RESP : WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latches, legality verdict and read-data capture.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      owner_q  <= REQ_CORE;
      addr_q   <= '0;
      wdata_q  <= '0;
      funct3_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        funct3_q <= sel_funct3;
        owner_q  <= grant;
        err_q    <= ~access_ok(sel_we, sel_funct3, sel_addr[1:0]);
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_W'(RD_LATENCY - 1);
      end else if (state_q == WAIT) begin
        if (cnt_q == '0) rdata_q <= mem_rdata_i;
        else             cnt_q   <= cnt_q - 1'b1;
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    case (state_q)
      IDLE: if (grant_vld) req_ready_o[grant] = 1'b1;
      ISSUE: begin
        mem_req_o = ~err_q;
        mem_we_o  = ~err_q & we_q;
      end
      RESP: begin
        rsp_valid_o[owner_q] = 1'b1;
        rsp_err_o            = err_q;
        if (!we_q && !err_q) rsp_rdata_o = rdata_q;
      end
      default: ;
    endcase
  end

  assign mem_addr_o   = addr_q;
  assign mem_wdata_o  = wdata_q;
  assign mem_funct3_o = funct3_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (read latency 1 and 4), a cycle-level
// transaction model per instance, and directed transactions with literal checks.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  int   cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]      tv_valid [2];
  logic [1:0]      tv_we    [2];
  logic [2*AW-1:0] tv_addr  [2];
  logic [2*DW-1:0] tv_wdata [2];
  logic [5:0]      tv_f3    [2];

  logic [1:0]    o_ready  [2];
  logic [1:0]    o_rsp    [2];
  logic [DW-1:0] o_rdata  [2];
  logic          o_err    [2];
  logic          o_mreq   [2];
  logic          o_mwe    [2];
  logic [AW-1:0] o_maddr  [2];
  logic [DW-1:0] o_mwdata [2];
  logic [2:0]    o_mf3    [2];
  logic          o_busy   [2];

  function automatic void chk(int d, string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL d%0d %s: got 0x%0h, expected 0x%0h (cycle %0d)", d, nm, act, exp, cyc);
    end
  endfunction

  function automatic void timeout(int d, string nm);
    n_tests++;
    n_fail++;
    $display("FAIL d%0d %s: timed out (cycle %0d)", d, nm, cyc);
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_dut
    localparam int LAT = (d == 0) ? 1 : 4;
    logic [DW-1:0] mrd;
    logic [DW-1:0] mem [64];
    int            rd_due;
    logic [AW-1:0] rd_addr;

    bit            m_busy, m_we, m_err, m_own, m_last;
    int            m_acc, m_rsp;
    logic [DW-1:0] m_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_f3;

    dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst_n),
      .req_valid_i  (tv_valid[d]),
      .req_ready_o  (o_ready[d]),
      .req_we_i     (tv_we[d]),
      .req_addr_i   (tv_addr[d]),
      .req_wdata_i  (tv_wdata[d]),
      .req_funct3_i (tv_f3[d]),
      .rsp_valid_o  (o_rsp[d]),
      .rsp_rdata_o  (o_rdata[d]),
      .rsp_err_o    (o_err[d]),
      .mem_req_o    (o_mreq[d]),
      .mem_we_o     (o_mwe[d]),
      .mem_addr_o   (o_maddr[d]),
      .mem_wdata_o  (o_mwdata[d]),
      .mem_funct3_o (o_mf3[d]),
      .mem_rdata_i  (mrd),
      .busy_o       (o_busy[d])
    );

    initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE0000 | i;
      mem[4]  = 32'hDEADBEEF;
      rd_due  = -1;
      rd_addr = '0;
      mrd     = 32'hBAD0BAD0;
      m_busy  = 0;
      m_last  = 1;
      m_acc   = 0;
      m_rsp   = 0;
      m_addr  = '0;
      m_wdata = '0;
      m_f3    = '0;
    end

    // Memory: data is only valid in the cycle exactly LAT after the command.
    always @(negedge clk) begin
      if (!rst_n) rd_due = -1;
      mrd = (cyc == rd_due) ? mem[rd_addr[7:2]] : 32'hBAD0BAD0;
      if (rst_n && o_mreq[d]) begin
        if (o_mwe[d]) mem[o_maddr[d][7:2]] = o_mwdata[d];
        else begin
          rd_due  = cyc + LAT;
          rd_addr = o_maddr[d];
        end
      end
    end

    always @(negedge clk) begin
      logic [1:0]    e_ready, e_rsp;
      logic [DW-1:0] e_rdata;
      logic          e_err, e_mreq, e_mwe;
      int            gi, sz;
      bit            legal;
      if (!rst_n) begin
        m_busy  = 0;
        m_last  = 1;
        m_addr  = '0;
        m_wdata = '0;
        m_f3    = '0;
        chk(d, "reset mem_req", o_mreq[d], 0);
        chk(d, "reset busy", o_busy[d], 0);
        chk(d, "reset rsp_valid", o_rsp[d], 0);
        chk(d, "reset mem_addr", o_maddr[d], 0);
      end else begin
        if (m_busy && cyc > m_rsp) m_busy = 0;
        e_ready = 2'b00;
        if (!m_busy) begin
          case (tv_valid[d])
            2'b01:   e_ready = 2'b01;
            2'b10:   e_ready = 2'b10;
            2'b11:   e_ready = m_last ? 2'b01 : 2'b10;
            default: e_ready = 2'b00;
          endcase
        end
        e_mreq  = m_busy && !m_err && (cyc == m_acc + 1);
        e_mwe   = e_mreq && m_we;
        e_rsp   = (m_busy && cyc == m_rsp) ? (m_own ? 2'b10 : 2'b01) : 2'b00;
        e_err   = (e_rsp != 0) && m_err;
        e_rdata = (e_rsp != 0 && !m_we && !m_err) ? m_rdata : '0;
        chk(d, "req_ready", o_ready[d], e_ready);
        chk(d, "rsp_valid", o_rsp[d], e_rsp);
        chk(d, "rsp_rdata", o_rdata[d], e_rdata);
        chk(d, "rsp_err", o_err[d], e_err);
        chk(d, "mem_req", o_mreq[d], e_mreq);
        chk(d, "mem_we", o_mwe[d], e_mwe);
        chk(d, "busy", o_busy[d], m_busy);
        chk(d, "mem_addr", o_maddr[d], m_addr);
        chk(d, "mem_wdata", o_mwdata[d], m_wdata);
        chk(d, "mem_funct3", o_mf3[d], m_f3);
        if (e_ready != 0) begin
          gi      = e_ready[1] ? 1 : 0;
          m_we    = tv_we[d][gi];
          m_addr  = tv_addr[d][gi*AW +: AW];
          m_wdata = tv_wdata[d][gi*DW +: DW];
          m_f3    = tv_f3[d][gi*3 +: 3];
          sz      = 1 << m_f3[1:0];
          legal   = m_we ? (m_f3 <= 3'd2) : (m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
          m_err   = !(legal && (int'(m_addr[1:0]) % sz == 0));
          m_own   = (gi == 1);
          m_last  = (gi == 1);
          m_acc   = cyc;
          m_busy  = 1;
          m_rsp   = cyc + ((m_we || m_err) ? 2 : 2 + LAT);
          m_rdata = mem[m_addr[7:2]];
        end
      end
    end
  end

  task automatic do_txn(input int d, input int r, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        output int acc, output int lat, output logic [31:0] rdata, output logic err);
    bit got;
    acc   = -1;
    lat   = -1;
    rdata = 32'hFFFF_FFFF;
    err   = 1'bx;
    @(posedge clk); #1;
    tv_we[d][r]              = we;
    tv_addr[d][r*AW +: AW]   = addr;
    tv_wdata[d][r*DW +: DW]  = wdata;
    tv_f3[d][r*3 +: 3]       = f3;
    tv_valid[d][r]           = 1'b1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (o_ready[d][r]) begin
        got = 1;
        acc = cyc;
      end
    end
    @(posedge clk); #1;
    tv_valid[d][r] = 1'b0;
    if (!got) begin
      timeout(d, "accept");
      return;
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (o_rsp[d][r]) begin
        got   = 1;
        lat   = cyc - acc;
        rdata = o_rdata[d];
        err   = o_err[d];
      end
    end
    if (!got) timeout(d, "response");
  endtask

  initial begin
    int          acc, lat, acc_b, lat_b, n;
    logic [31:0] rd, rd_b;
    logic        er, er_b;
    int          order [4];
    int          exp_order [4];
    exp_order = '{0, 1, 0, 1};
    for (int d = 0; d < 2; d++) begin
      tv_valid[d] = '0;
      tv_we[d]    = '0;
      tv_addr[d]  = '0;
      tv_wdata[d] = '0;
      tv_f3[d]    = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(0, "lit reset busy", o_busy[0], 0);
    chk(1, "lit reset mem_req", o_mreq[1], 0);
    @(negedge clk); #1;
    rst_n = 1'b1;

    // Both requesters valid from reset: core wins the first tie, then alternate.
    @(posedge clk); #1;
    tv_we[0]    = 2'b00;
    tv_addr[0]  = {32'h20, 32'h10};
    tv_f3[0]    = {3'b010, 3'b010};
    tv_valid[0] = 2'b11;
    for (int i = 0; i < 4; i++) order[i] = -1;
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (o_ready[0] != 2'b00) begin
        order[n] = o_ready[0][1] ? 1 : 0;
        n++;
      end
    end
    @(posedge clk); #1;
    tv_valid[0] = 2'b00;
    for (int i = 0; i < 4; i++) chk(0, $sformatf("tie grant %0d", i), order[i], exp_order[i]);
    repeat (6) @(posedge clk);

    do_txn(0, 0, 0, 32'h10, 32'h0, 3'b010, acc, lat, rd, er);
    chk(0, "rd word latency", lat, 3);
    chk(0, "rd word data", rd, 32'hDEADBEEF);
    chk(0, "rd word err", er, 0);

    do_txn(0, 1, 1, 32'h22, 32'h1234, 3'b001, acc, lat, rd, er);
    chk(0, "wr half latency", lat, 2);
    chk(0, "wr half rdata", rd, 0);
    chk(0, "wr half err", er, 0);
    do_txn(0, 1, 0, 32'h20, 32'h0, 3'b010, acc, lat, rd, er);
    chk(0, "readback after wr", rd, 32'h00001234);

    do_txn(0, 0, 0, 32'h13, 32'h0, 3'b010, acc, lat, rd, er);
    chk(0, "misaligned word latency", lat, 2);
    chk(0, "misaligned word err", er, 1);
    chk(0, "misaligned word rdata", rd, 0);
    do_txn(0, 1, 1, 32'h08, 32'h55, 3'b100, acc, lat, rd, er);
    chk(0, "store f3 100 err", er, 1);
    do_txn(0, 0, 0, 32'h00, 32'h0, 3'b011, acc, lat, rd, er);
    chk(0, "load f3 011 err", er, 1);
    do_txn(0, 0, 0, 32'h11, 32'h0, 3'b101, acc, lat, rd, er);
    chk(0, "load hu odd err", er, 1);
    do_txn(0, 0, 0, 32'h13, 32'h0, 3'b000, acc, lat, rd, er);
    chk(0, "load byte odd err", er, 0);
    chk(0, "load byte odd latency", lat, 3);
    do_txn(0, 0, 1, 32'h24, 32'hA5A55A5A, 3'b010, acc, lat, rd, er);
    chk(0, "store word err", er, 0);
    do_txn(0, 1, 0, 32'h24, 32'h0, 3'b010, acc, lat, rd, er);
    chk(0, "store word readback", rd, 32'hA5A55A5A);

    // Latency 4: core request raised mid-WAIT waits until after the response.
    fork
      do_txn(1, 1, 0, 32'h10, 32'h0, 3'b010, acc, lat, rd, er);
      begin
        repeat (3) @(posedge clk);
        do_txn(1, 0, 0, 32'h20, 32'h0, 3'b010, acc_b, lat_b, rd_b, er_b);
      end
    join
    chk(1, "lat4 read latency", lat, 6);
    chk(1, "lat4 read data", rd, 32'hDEADBEEF);
    chk(1, "lat4 blocked core accept", acc_b - acc, 7);
    chk(1, "lat4 core data", rd_b, 32'hC0DE0008);

    // Asynchronous reset in the middle of a latency-4 read.
    @(posedge clk); #1;
    tv_we[1][1]      = 1'b0;
    tv_addr[1][63:32] = 32'h10;
    tv_f3[1][5:3]    = 3'b010;
    tv_valid[1][1]   = 1'b1;
    @(negedge clk);
    chk(1, "pre-reset ready", o_ready[1], 2'b10);
    @(posedge clk); #1;
    tv_valid[1][1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    chk(1, "busy in wait", o_busy[1], 1);
    rst_n = 1'b0;
    #1;
    chk(1, "async reset busy", o_busy[1], 0);
    chk(1, "async reset mem_req", o_mreq[1], 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk(1, "no rsp after reset", o_rsp[1], 0);
    end
    @(posedge clk); #1;
    tv_addr[1]  = {32'h20, 32'h10};
    tv_f3[1]    = {3'b010, 3'b010};
    tv_we[1]    = 2'b00;
    tv_valid[1] = 2'b11;
    @(negedge clk);
    chk(1, "tie after reset", o_ready[1], 2'b01);
    @(posedge clk); #1;
    tv_valid[1] = 2'b00;
    repeat (10) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
